train_sensor_conditioner: RTL
=============================

// Module: train_sensor_conditioner
// PURPOSE
//  Front end for the gate controller. Conditions two raw trackside presence sensors: approach (entry) and departure (exit).
//  Tracks one train through the crossing zone; emits single-cycle entry/exit pulses to the gate/signal FSM.
//  Flags stuck or out-of-order sensor behaviour as a latched fault.
// PARAMETERS
//  DEBOUNCE_CYCLES  100000      consecutive stable cycles before a debounced level changes (1 ms @100 MHz)
//  DB_W             17          debounce counter width; must hold DEBOUNCE_CYCLES
//  TIMEOUT_CYCLES   1000000000  max cycles a train may stay in the zone before fault (10 s @100 MHz)
//  TO_W             30          timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk             in   1  system clock
//  rst             in   1  synchronous, active-high reset
//  sens_entry_raw  in   1  approach sensor, asynchronous, 1 = train present
//  sens_exit_raw   in   1  departure sensor, asynchronous, 1 = train present
//  entry           out  1  one-cycle pulse: train has arrived at the approach sensor
//  exit            out  1  one-cycle pulse: train has fully cleared the departure sensor
//  occupied        out  1  high while a train is being tracked (ARRIVING/IN_ZONE/LEAVING)
//  fault           out  1  latched sensor/sequence fault; cleared only by rst
//  entry_db        out  1  debounced approach sensor level (diagnostic)
//  exit_db         out  1  debounced departure sensor level (diagnostic)
// BEHAVIOUR
//  Reset: all outputs 0; sync flops, debounced levels and all counters 0; state = IDLE.
//  Input path, per sensor: 2-flop synchroniser -> debouncer.
//   - Debounced level flips only after the synced value differs from it for DEBOUNCE_CYCLES consecutive cycles.
//   - Any cycle where synced == debounced clears the counter.
//   - Latency from a clean raw edge to the debounced edge: 2 + DEBOUNCE_CYCLES cycles.
//  FSM (registered state; evaluates debounced levels and their 1-cycle edge detects):
//   IDLE:     entry_db rise -> ARRIVING, entry=1 in the first ARRIVING cycle.
//             exit_db rise (wrong direction) -> FAULT. Both rise same cycle -> FAULT.
//   ARRIVING: exit_db rise -> LEAVING (long train covers both). Otherwise entry_db fall -> IN_ZONE.
//             Exit rise has priority over entry fall.
//   IN_ZONE:  exit_db rise -> LEAVING. entry_db rise (second train before clearance) -> FAULT.
//   LEAVING:  when entry_db==0 && exit_db==0 -> IDLE, exit=1 in the first IDLE cycle.
//             A new entry_db rise while exit_db still high -> FAULT.
//   FAULT:    absorbing. entry/exit held 0, fault=1, occupied=0. Exits only via rst. The downstream gate stays closed.
//  Timeout: counter clears on entry to ARRIVING and increments every cycle in ARRIVING/IN_ZONE/LEAVING.
//   - Reaching TIMEOUT_CYCLES -> FAULT next cycle; the timeout check beats any same-cycle transition.
//   - The counter saturates and never wraps.
//  entry and exit are never both high in the same cycle. Each pulse is exactly 1 cycle.
//  Reset mid-train: tracking is lost and the FSM goes to IDLE.
//   - If the approach sensor is still covered, a fresh entry pulse fires after debounce.
//   - If only the departure sensor is covered, FAULT (deliberately fail-safe).
//  All outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//  Shared package rail_pkg holds:
//   - FSM state encodings IDLE=0, ARRIVING=1, IN_ZONE=2, LEAVING=3, FAULT=4 (3 bits)
//   - CLK_HZ=100_000_000 and the derived default cycle constants
//  One sub-module, sensor_debounce (synchroniser + counter + debounced level + rise/fall strobes), instantiated twice.
//  The top holds the FSM, the timeout counter and the output registers.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50)
//  1. Normal pass.
//     - Stimulus: entry raw high 20 cyc, then exit raw high 20 cyc, then low.
//     - Response: entry pulse 7 cyc after entry raw rise; occupied=1 throughout; exit pulse 1 cyc after exit_db falls; then IDLE.
//  2. Bounce.
//     - Stimulus: entry raw toggles every 2 cyc for 30 cyc, then stays low.
//     - Response: entry_db stays 0; no entry pulse; state stays IDLE.
//  3. Long train.
//     - Stimulus: entry raw high, exit raw rises while entry still high; entry falls, then exit falls.
//     - Response: path ARRIVING->LEAVING; exactly one entry pulse and one exit pulse.
//  4. Wrong direction.
//     - Stimulus: exit raw high 10 cyc from IDLE.
//     - Response: fault=1 at cycle 7 after rise; later entry activity gives no pulses; rst clears fault.
//  5. Timeout.
//     - Stimulus: entry raw held high 80 cyc.
//     - Response: fault rises 51 cyc after the entry pulse; occupied drops to 0.
//  6. Mid-train reset.
//     - Stimulus: rst for 1 cyc during IN_ZONE, with no sensor covered.
//     - Response: all outputs 0 next cycle; a following exit raw rise gives FAULT.

Source files
------------

// File: rtl/rail_pkg.sv
// rail_pkg: shared FSM encodings and default cycle constants for the crossing front end
package rail_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARRIVING = 3'd1,
    IN_ZONE  = 3'd2,
    LEAVING  = 3'd3,
    FAULT    = 3'd4
  } state_t;
  localparam int CLK_HZ       = 100_000_000;
  localparam int DEBOUNCE_DEF = CLK_HZ / 1000;
  localparam int TIMEOUT_DEF  = CLK_HZ * 10;
endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: two-flop synchroniser, stability counter, debounced level and edge strobes
module sensor_debounce
  import rail_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int DB_W            = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic            r_meta;
  logic            r_sync;
  logic            r_db;
  logic            r_prev;
  logic [DB_W-1:0] r_cnt;
  // level flips only after the synced input has disagreed with it for a full run of cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_db   <= 1'b0;
      r_prev <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      r_prev <= r_db;
      if (r_sync == r_db) r_cnt <= '0;
      else if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt <= '0;
        r_db  <= r_sync;
      end else r_cnt <= r_cnt + DB_W'(1);
    end
  end
  assign o_level = r_db;
  assign o_rise  = r_db & ~r_prev;
  assign o_fall  = ~r_db & r_prev;
endmodule

// File: rtl/train_sensor_conditioner.sv
// train_sensor_conditioner: tracks one train across the crossing and raises entry/exit pulses or a latched fault
module train_sensor_conditioner
  import rail_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int DB_W            = 17,
  parameter int TIMEOUT_CYCLES  = TIMEOUT_DEF,
  parameter int TO_W            = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic sens_entry_raw,
  input  logic sens_exit_raw,
  output logic entry,
  output logic exit,
  output logic occupied,
  output logic fault,
  output logic entry_db,
  output logic exit_db
);
  state_t          r_state;
  state_t          w_next;
  logic [TO_W-1:0] r_to;
  logic            w_en_lvl, w_en_rise, w_en_fall;
  logic            w_ex_lvl, w_ex_rise, w_ex_fall;
  logic            w_track, w_to_hit, w_clear;
  logic            w_entry, w_exit, w_occ, w_fault;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_entry_db (
    .clk(clk), .rst(rst), .i_raw(sens_entry_raw),
    .o_level(w_en_lvl), .o_rise(w_en_rise), .o_fall(w_en_fall)
  );
  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_exit_db (
    .clk(clk), .rst(rst), .i_raw(sens_exit_raw),
    .o_level(w_ex_lvl), .o_rise(w_ex_rise), .o_fall(w_ex_fall)
  );

  assign w_track  = (r_state == ARRIVING) || (r_state == IN_ZONE) || (r_state == LEAVING);
  assign w_to_hit = w_track && (r_to == TO_W'(TIMEOUT_CYCLES));
  // the zone is clear on the cycle the last covered sensor releases
  assign w_clear  = (w_ex_fall && !w_en_lvl) || (w_en_fall && !w_ex_lvl);

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end

  // next-state decode; the timeout overrides any transition and undefined codes fail safe
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = w_ex_rise ? FAULT : (w_en_rise ? ARRIVING : IDLE);
      ARRIVING: w_next = w_ex_rise ? LEAVING : (w_en_fall ? IN_ZONE : ARRIVING);
      IN_ZONE:  w_next = w_en_rise ? FAULT : (w_ex_rise ? LEAVING : IN_ZONE);
      LEAVING:  w_next = (w_en_rise && w_ex_lvl) ? FAULT : (w_clear ? IDLE : LEAVING);
      default:  w_next = FAULT;
    endcase
    if (w_to_hit) w_next = FAULT;
  end

  // output decode from the transition about to be taken
  always_comb begin
    w_entry = (r_state == IDLE) && (w_next == ARRIVING);
    w_exit  = (r_state == LEAVING) && (w_next == IDLE);
    w_occ   = (w_next == ARRIVING) || (w_next == IN_ZONE) || (w_next == LEAVING);
    w_fault = (w_next == FAULT);
  end

  // registered outputs so nothing downstream sees a combinational input path
  always_ff @(posedge clk) begin
    if (rst) begin
      entry    <= 1'b0;
      exit     <= 1'b0;
      occupied <= 1'b0;
      fault    <= 1'b0;
    end else begin
      entry    <= w_entry;
      exit     <= w_exit;
      occupied <= w_occ;
      fault    <= w_fault;
    end
  end

  // dwell timer: restarts when a train is picked up, saturates at the limit
  always_ff @(posedge clk) begin
    if (rst) r_to <= '0;
    else if (w_entry) r_to <= '0;
    else if (w_track && !w_to_hit) r_to <= r_to + TO_W'(1);
  end

  assign entry_db = w_en_lvl;
  assign exit_db  = w_ex_lvl;
endmodule
